wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of entries in the deferred-result FIFO (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 3, SHALL set the number of consecutive blocked cycles before stall_req asserts (>=1).
REQ-003 The block SHALL have one clock, and reset SHALL be synchronous and active-high.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous active-high reset.
REQ-006 Port RegWriteW, input, 1: the pipeline writeback stage requests a register write this cycle.
REQ-007 Port RdW, input, 5: the pipeline writeback destination register.
REQ-008 Port ResultW, input, 32: the pipeline writeback data.
REQ-009 Port mdu_valid, input, 1: the multi-cycle unit (mul/div) offers a result.
REQ-010 Port mdu_rd, input, 5: the multi-cycle result destination register.
REQ-011 Port mdu_data, input, 32: the multi-cycle result data.
REQ-012 Port mdu_ready, output, 1: the arbiter accepts the multi-cycle result this cycle.
REQ-013 Port rf_we, output, 1: the register-file write enable.
REQ-014 Port rf_waddr, output, 5: the register-file write address.
REQ-015 Port rf_wdata, output, 32: the register-file write data.
REQ-016 Port rf_src, output, 1: the write source, 0 = pipeline, 1 = multi-cycle unit (FIFO or bypass).
REQ-017 Port stall_req, output, 1, registered: asks upstream to insert one writeback bubble.
REQ-018 Port fifo_count, output, $clog2(DEPTH+1): the current FIFO occupancy.

Function
REQ-019 The pipeline SHALL have absolute priority: if RegWriteW=1 and RdW!=0, then rf_we=1, rf_waddr=RdW, rf_wdata=ResultW and rf_src=0, combinationally in the same cycle.
REQ-020 The write port SHALL be free when RegWriteW=0 or RdW=0; a pipeline write to x0 SHALL be suppressed and SHALL NOT consume the port.
REQ-021 If the port is free and the FIFO is non-empty, the FIFO head SHALL be written (rf_src=1) and dequeued at the clock edge.
REQ-022 If the port is free, the FIFO is empty, and mdu_valid=1 with mdu_rd!=0, the result SHALL be written directly in the same cycle (bypass) and SHALL NOT be enqueued.
REQ-023 mdu_ready SHALL equal (fifo_count<DEPTH) and SHALL NOT depend on the port state.
REQ-024 A handshake (mdu_valid & mdu_ready) SHALL be enqueued unless it is bypassed or mdu_rd=0; an mdu_rd=0 result SHALL be accepted and dropped.
REQ-025 An enqueued entry SHALL be eligible for writing no earlier than the next cycle; results SHALL drain in FIFO order.
REQ-026 A simultaneous enqueue and dequeue SHALL leave fifo_count unchanged, with the pointers wrapping modulo DEPTH.
REQ-027 When rf_we=0, rf_waddr, rf_wdata and rf_src SHALL all be 0.
REQ-028 A starvation counter SHALL increment each cycle in which fifo_count>0 and no dequeue occurs, SHALL saturate at STARVE_LIMIT, and SHALL clear on any dequeue or when the FIFO is empty.
REQ-029 stall_req SHALL be registered, equal to (starvation counter >= STARVE_LIMIT), and SHALL fall the cycle after the dequeue that clears the counter.
REQ-030 Write ordering to the same register between the pipeline and the multi-cycle unit is the issuer's responsibility; the arbiter SHALL NOT reorder or merge entries.

Reset
REQ-031 While rst=1 at a clock edge, the FIFO pointers, fifo_count, starvation counter and stall_req SHALL all clear to 0.
REQ-032 While rst=1, rf_we, rf_waddr, rf_wdata, rf_src and mdu_ready SHALL be forced to 0 combinationally.
REQ-033 A reset asserted mid-operation SHALL discard all queued entries without writing them.

Verification
REQ-034 Scenario: FIFO empty, RegWriteW=0, mdu_valid=1, mdu_rd=5, mdu_data=0xDEADBEEF -> same cycle rf_we=1, rf_waddr=5, rf_src=1, and fifo_count stays 0.
REQ-035 Scenario: RegWriteW=1, RdW=3, ResultW=0x11 while mdu_valid=1, mdu_rd=7 -> rf_waddr=3, rf_src=0; next cycle fifo_count=1; first free cycle rf_waddr=7, rf_src=1.
REQ-036 Scenario: RegWriteW=1, RdW=1..31 every cycle with 4 MDU results -> fifo_count=4, mdu_ready=0; stall_req=1 after 3 blocked cycles; one bubble drains one entry and stall_req clears the following cycle.
REQ-037 Scenario: FIFO holds 2 entries, RegWriteW=1, RdW=0 -> head written (rf_src=1) and fifo_count goes to 1.
REQ-038 Scenario: FIFO holds 3 entries, then rst=1 for 1 cycle -> fifo_count=0, stall_req=0, and no queued entry is ever written.
REQ-039 Scenario: mdu_valid=1, mdu_rd=0 while the FIFO is full-1 -> accepted, fifo_count unchanged, rf_we=0 from that source.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the writeback pipeline, the multi-cycle unit, and the register-file write port.
// The arbiter takes the slave view; whatever drives it takes the master view.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          RegWriteW;
  logic [4:0]    RdW;
  logic [31:0]   ResultW;
  logic          mdu_valid;
  logic [4:0]    mdu_rd;
  logic [31:0]   mdu_data;
  logic          mdu_ready;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;
  logic          rf_src;
  logic          stall_req;
  logic [CW-1:0] fifo_count;

  modport slave (
    input  RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, fifo_count
  );

  modport master (
    output RegWriteW, RdW, ResultW, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, rf_src, stall_req, fifo_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the pipeline (always wins) and a multi-cycle unit.
// Results from the multi-cycle unit that cannot be written at once wait in a small FIFO.
module wb_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_q, stall_d;

  logic pipe_wr, fifo_empty, ready, deq, bypass, enq;

  // A pipeline write to x0 is a no-op and leaves the port free for the multi-cycle side.
  assign pipe_wr    = bus.RegWriteW && (bus.RdW != 5'd0);
  assign fifo_empty = (count_q == '0);
  assign ready      = !rst && (count_q < FULL);
  assign deq        = !rst && !pipe_wr && !fifo_empty;
  assign bypass     = !rst && !pipe_wr && fifo_empty && bus.mdu_valid && (bus.mdu_rd != 5'd0);
  assign enq        = bus.mdu_valid && ready && !bypass && (bus.mdu_rd != 5'd0);

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    bus.rf_src   = 1'b0;
    if (!rst) begin
      if (pipe_wr) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.RdW;
        bus.rf_wdata = bus.ResultW;
      end else if (deq) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = rd_mem[rd_ptr_q];
        bus.rf_wdata = data_mem[rd_ptr_q];
        bus.rf_src   = 1'b1;
      end else if (bypass) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.mdu_rd;
        bus.rf_wdata = bus.mdu_data;
        bus.rf_src   = 1'b1;
      end
    end
  end

  assign bus.mdu_ready  = ready;
  assign bus.fifo_count = count_q;
  assign bus.stall_req  = stall_q;

  always_comb begin
    rd_ptr_d = deq ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = enq ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q + CW'(enq) - CW'(deq);
    // Counts cycles the head has been waiting behind the pipeline.
    if (fifo_empty || deq)    starve_d = '0;
    else if (starve_q < SLIM) starve_d = starve_q + SW'(1);
    else                      starve_d = starve_q;
    stall_d = (starve_d >= SLIM);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count already makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (enq) begin
      rd_mem[wr_ptr_q]   <= bus.mdu_rd;
      data_mem[wr_ptr_q] <= bus.mdu_data;
    end
  end
endmodule
